// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
//   Types and constants shared by the store buffer, the store-data formatter
//   and the load extractor.
//   - BYTE_LANES / WORD_LSB : lane count and byte-offset width of a data word
//   - lane_mask_t           : per-lane byte enable
//   - sb_payload_t          : lane-aligned data plus mask of one entry.
//                             The entry also carries a valid bit and a word
//                             address; those are kept beside the payload in
//                             the buffer because the address width follows AW.
//   - byte_merge()          : lane-wise replace used when stores coalesce
package store_buffer_pkg;

  localparam int BYTE_LANES = 4;
  localparam int WORD_LSB   = 2;
  localparam int DATA_W     = 8 * BYTE_LANES;

  typedef logic [BYTE_LANES-1:0] lane_mask_t;

  localparam lane_mask_t MASK_NONE = 4'b0000;
  localparam lane_mask_t MASK_HALF_LO = 4'b0011;
  localparam lane_mask_t MASK_HALF_HI = 4'b1100;
  localparam lane_mask_t MASK_WORD = 4'b1111;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    lane_mask_t        mask;
  } sb_payload_t;

  // Replace only the lanes selected by m; other lanes keep old_d.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_d,
                                                  input logic [DATA_W-1:0] new_d,
                                                  input lane_mask_t        m);
    logic [DATA_W-1:0] r;
    r = old_d;
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (m[i]) r[8*i +: 8] = new_d[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// store_buffer_match
//   Compares one buffered store against a load lookup: hit when the entry is
//   valid, the word addresses are equal and the byte masks overlap.
//   Ports: entry_valid/entry_waddr/entry_mask (buffered store),
//          ld_waddr/ld_mask (load), hit (overlap).
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int WAW = 30
) (
  input  logic           entry_valid,
  input  logic [WAW-1:0] entry_waddr,
  input  lane_mask_t     entry_mask,
  input  logic [WAW-1:0] ld_waddr,
  input  lane_mask_t     ld_mask,
  output logic           hit
);

  assign hit = entry_valid && (entry_waddr == ld_waddr) && ((entry_mask & ld_mask) != MASK_NONE);

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write queue between the store formatter and the data-memory write
//   port. Stores drain in order over a valid/ready handshake; a combinational
//   lookup flags loads overlapping any buffered store.
//   Ports:
//     clk, rst_n                          clock, async active-low reset
//     enq_valid/enq_ready/addr/data/mask  store input from MEM stage
//     mem_wr_valid/ready/addr/data/mask   head entry to memory
//     ld_valid/ld_addr/ld_mask/ld_hazard  load overlap lookup
//     empty, count                        occupancy
//   Build option: STORE_BUF_COALESCE_EN merges a store into the tail entry
//   when it targets the same word and at least two entries are held.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [AW-1:0]            enq_addr,
  input  logic [31:0]              enq_data,
  input  logic [3:0]               enq_mask,
  output logic                     mem_wr_valid,
  input  logic                     mem_wr_ready,
  output logic [AW-1:0]            mem_wr_addr,
  output logic [31:0]              mem_wr_data,
  output logic [3:0]               mem_wr_mask,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  input  logic [3:0]               ld_mask,
  output logic                     ld_hazard,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WAW = AW - WORD_LSB;

  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WAW-1:0] waddr_q [DEPTH];
  logic [WAW-1:0] waddr_d [DEPTH];
  sb_payload_t    pay_q [DEPTH];
  sb_payload_t    pay_d [DEPTH];

  logic [WAW-1:0] enq_waddr;
  logic [WAW-1:0] ld_waddr;
  logic [PW-1:0]  tail_last;
  logic           full;
  logic           merge_hit;
  logic           enq_fire;
  logic           do_push;
  logic           do_merge;
  logic           pop;
  logic [DEPTH-1:0] hit_vec;
  logic           unused_low_bits;

  assign enq_waddr = enq_addr[AW-1:WORD_LSB];
  assign ld_waddr  = ld_addr[AW-1:WORD_LSB];
  assign unused_low_bits = ^{enq_addr[WORD_LSB-1:0], ld_addr[WORD_LSB-1:0]};

  assign tail_last = tail_q - PW'(1);
  assign full      = (count_q == CW'(DEPTH));

`ifdef STORE_BUF_COALESCE_EN
  // count>=2 keeps the tail distinct from the head, so a merge never
  // touches an entry that memory may be accepting this cycle.
  assign merge_hit = (enq_mask != MASK_NONE) && (count_q >= CW'(2)) &&
                     (waddr_q[tail_last] == enq_waddr);
  assign enq_ready = !full || merge_hit;
`else
  assign merge_hit = 1'b0;
  assign enq_ready = !full;
`endif

  assign enq_fire = enq_valid && enq_ready;
  assign do_merge = enq_fire && merge_hit;
  assign do_push  = enq_fire && !merge_hit && (enq_mask != MASK_NONE);

  // Outputs are zeroed while nothing is presented so stale entries never leak.
  assign mem_wr_valid = valid_q[head_q];
  assign mem_wr_addr  = mem_wr_valid ? {waddr_q[head_q], {WORD_LSB{1'b0}}} : '0;
  assign mem_wr_data  = mem_wr_valid ? pay_q[head_q].data : '0;
  assign mem_wr_mask  = mem_wr_valid ? pay_q[head_q].mask : '0;
  assign pop          = mem_wr_valid && mem_wr_ready;

  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    waddr_d = waddr_q;
    pay_d   = pay_q;
    count_d = count_q;

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    if (do_push) begin
      valid_d[tail_q]     = 1'b1;
      waddr_d[tail_q]     = enq_waddr;
      pay_d[tail_q].data  = enq_data;
      pay_d[tail_q].mask  = enq_mask;
      tail_d              = tail_q + PW'(1);
    end

    if (do_merge) begin
      pay_d[tail_last].data = byte_merge(pay_q[tail_last].data, enq_data, enq_mask);
      pay_d[tail_last].mask = pay_q[tail_last].mask | enq_mask;
    end

    case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry contents are qualified by valid_q and need no reset.
  always_ff @(posedge clk) begin
    waddr_q <= waddr_d;
    pay_q   <= pay_d;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    store_buffer_match #(.WAW(WAW)) u_match (
      .entry_valid (valid_q[g]),
      .entry_waddr (waddr_q[g]),
      .entry_mask  (pay_q[g].mask),
      .ld_waddr    (ld_waddr),
      .ld_mask     (ld_mask),
      .hit         (hit_vec[g])
    );
  end

  assign ld_hazard = ld_valid && (|hit_vec);

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write queue between the store-data formatter (byte-lane-aligned data plus 4-bit byte mask) and the data-memory write port.
- Accepts one store per cycle from the MEM stage and drains in order to memory over a valid/ready handshake.
- Reports load/store byte-overlap hazards so the core stalls loads that would read stale memory.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- AW, 32, byte-address width; the word address is addr[AW-1:2].

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enq_valid  in  1  store request from MEM stage.
- enq_ready  out  1  buffer can accept the store this cycle.
- enq_addr  in  AW  store byte address; bits [1:0] ignored.
- enq_data  in  32  lane-aligned store data; unmasked lanes may be X.
- enq_mask  in  4  byte-lane write enables.
- mem_wr_valid  out  1  head entry presented to memory.
- mem_wr_ready  in  1  memory accepts the head entry.
- mem_wr_addr  out  AW  head word address, with bits [1:0] = 0.
- mem_wr_data  out  32  head data.
- mem_wr_mask  out  4  head byte enables.
- ld_valid  in  1  load lookup is active.
- ld_addr  in  AW  load byte address.
- ld_mask  in  4  load byte lanes.
- ld_hazard  out  1  the load overlaps a buffered store.
- empty  out  1  no valid entries.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Pointers, count and all entry valid bits are cleared.
  - Outputs: mem_wr_valid=0, mem_wr_mask=0, mem_wr_addr=0, mem_wr_data=0, empty=1, count=0, ld_hazard=0.
  - enq_ready=1 once rst_n=1.
- Reset mid-drain: the entry is discarded. Memory must treat a write as committed only on a valid&&ready edge.
- Storage: circular FIFO with head/tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus a separate occupancy count.
- Enqueue:
  - The entry is written at the edge where enq_valid && enq_ready.
  - enq_ready = (count < DEPTH) when the optional feature is off. It is computed from registered state only and is never raised by a same-cycle dequeue.
  - enq_mask == 4'b0000 is accepted (enq_ready honoured) but not stored, and count is unchanged.
- Drain:
  - mem_wr_* are driven directly from the head entry, with no extra latency.
  - An entry enqueued at edge N is visible on mem_wr_valid after edge N when the buffer was empty, so enqueue-to-memory latency is 1 cycle.
  - Head is popped on the edge where mem_wr_valid && mem_wr_ready. Outputs must stay stable while valid is high and ready is low.
- Simultaneous push and pop:
  - count is unchanged; both pointers advance.
  - When count==DEPTH, the push is refused (enq_ready=0) even if a pop occurs in that cycle.
  - When count==1 with push and pop together, the new entry becomes head on the next cycle.
- Hazard check (combinational):
  - ld_hazard = ld_valid && any valid entry E with E.addr[AW-1:2]==ld_addr[AW-1:2] && (E.mask & ld_mask)!=0.
  - The entry being popped this cycle still counts.
  - The entry being pushed this cycle does not count; the core's MEM-stage ordering covers it.
- Ordering: memory writes are issued strictly in enqueue order; no reordering.
- Unmasked data lanes are don't-care. A bench compares only bytes with the mask bit set.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined:
  - An enqueue merges into the tail entry when count>=2, the tail word address equals the enqueue word address, and enq_mask!=0.
  - The merge sets tail.mask |= enq_mask and replaces only the bytes whose enq_mask bit is set. count is unchanged.
  - enq_ready = (count<DEPTH) || merge_hit, so a full buffer still accepts a merging store.
  - A merge is never made into the head entry; count>=2 guarantees this.
- Undefined: no merging; every nonzero-mask store occupies its own entry.

Decomposition:
- Shared package/header, owned with the load/store path:
  - Constants: BYTE_LANES=4, WORD_LSB=2.
  - Entry field layout: valid, word address, data, mask.
  - Mask encodings shared with the store formatter and load extractor.
- One sub-module: store_buffer_match. Compares one entry against a load (word address equality plus mask overlap) and is instantiated DEPTH times, feeding an OR-reduce.

Test Plan:
- Single store, mem_wr_ready=1: enq 0x1000/0xDEADBEEF/4'b1111 at cycle 0 -> cycle 1 mem_wr_valid=1, addr 0x1000, mask 4'hF; cycle 2 empty=1.
- Fill with mem_wr_ready=0: 4 stores to 0x0,0x4,0x8,0xC -> count=4, enq_ready=0. Then raise ready -> four writes in order, 1 per cycle, with data stable during the stall.
- Push and pop at count==4: enq_ready=0 and the store is refused. At count==3 with push and pop together -> count stays 3.
- Hazard: buffer holds 0x2000 mask 4'b0011, ready=0. A load at 0x2002 with mask 4'b0100 gives ld_hazard=0; a load with mask 4'b0010 gives ld_hazard=1; ld_valid=0 gives 0.
- Zero mask and reset: enq mask 0 -> count stays 0. Assert rst_n=0 mid-drain with 3 entries -> immediately count=0, mem_wr_valid=0.
- STORE_BUF_COALESCE_EN: entries at 0x10 then 0x20 mask 4'b0001 data 0x11. Enq 0x20 mask 4'b0100 data 0x00330000 -> count=2, tail mask 4'b0101, bytes 0x33/0x11. The same sequence without the macro gives count=3.
